// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver FSM states and bit helpers shared by the UART blocks
// Contents: PARITY_NONE/EVEN/ODD, state_t, majority3(), parity9()
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity9(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick, one-cycle pulse every DIVISOR clocks
// Ports: i_clk clock, i_rst_n sync active-low reset, o_tick registered tick pulse
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIVISOR = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == W'(DIVISOR - 1)) ? '0 : r_cnt + W'(1);
            o_tick <= (r_cnt == W'(DIVISOR - 1));
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with majority vote and valid/ready output
// Ports: IN_CLOCK clock, IN_RESET_N sync active-low reset, IN_RX_SERIAL async RX line,
//        OUT_RX_DATA/OUT_RX_VALID/IN_RX_READY word handshake, OUT_RX_PARITY_ERROR,
//        OUT_RX_FRAME_ERROR, OUT_RX_OVERRUN word flags, OUT_RX_BREAK break in progress
// Option: UART_RX_BREAK_DETECT_EN turns an all-zero frame into a BREAK condition
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 9600,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 IN_CLOCK,
    input  logic                 IN_RESET_N,
    input  logic                 IN_RX_SERIAL,
    output logic [DATA_BITS-1:0] OUT_RX_DATA,
    output logic                 OUT_RX_VALID,
    input  logic                 IN_RX_READY,
    output logic                 OUT_RX_PARITY_ERROR,
    output logic                 OUT_RX_FRAME_ERROR,
    output logic                 OUT_RX_OVERRUN,
    output logic                 OUT_RX_BREAK
);

    localparam int DIVISOR = CLOCK_FREQUENCY / (UART_BAUD_RATE * OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;
    localparam int SW      = $clog2(OVERSAMPLE);
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN  = 1'b1;
`else
    localparam bit BRK_EN  = 1'b0;
`endif

    if (DIVISOR < 1) begin : g_div_check
        $error("uart_rx_oversampled: clock too slow for baud rate and oversample");
    end

    logic [1:0]           r_sync;
    state_t               r_state;
    logic                 r_armed;
    logic [SW-1:0]        r_smp;
    logic [3:0]           r_bit;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_err;
    logic                 r_all_zero;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 r_break;

    logic w_tick;
    logic w_rx;
    logic w_vote;
    logic w_mid;
    logic w_last;
    logic w_ferr;
    logic w_brk;
    logic w_deliver;
    logic w_perr;

    uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
        .i_clk   (IN_CLOCK),
        .i_rst_n (IN_RESET_N),
        .o_tick  (w_tick)
    );

    assign w_rx      = r_sync[1];
    // samples at M-1 and M are held; the third comes live at M+1, where every bit is decided
    assign w_vote    = majority3(r_s0, r_s1, w_rx);
    assign w_mid     = w_tick && (r_smp == SW'(M + 1));
    assign w_last    = (r_state == ST_STOP) && w_mid && (r_bit == 4'(STOP_BITS - 1));
    assign w_ferr    = r_stop_err | ~w_vote;
    assign w_brk     = BRK_EN & r_all_zero & ~w_vote;
    assign w_deliver = w_last & ~w_brk;
    assign w_perr    = (PARITY == PARITY_NONE) ? 1'b0 :
                       parity9(9'(r_shift)) ^ r_par_bit ^ (PARITY == PARITY_ODD);

    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            r_sync     <= 2'b11;
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_smp      <= '0;
            r_bit      <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_err <= 1'b0;
            r_all_zero <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
            r_break    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], IN_RX_SERIAL};
            if (w_tick) begin
                r_smp <= (r_smp == SW'(OVERSAMPLE - 1)) ? '0 : r_smp + SW'(1);
                if (r_smp == SW'(M - 1)) r_s0 <= w_rx;
                if (r_smp == SW'(M))     r_s1 <= w_rx;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && w_rx) r_armed <= 1'b1;
                    // disarming on start means a low line must be seen high again before the next frame
                    if (r_armed && !w_rx) begin
                        r_state    <= ST_START;
                        r_armed    <= 1'b0;
                        r_smp      <= '0;
                        r_bit      <= '0;
                        r_stop_err <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_mid) r_state <= w_vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= r_all_zero & ~w_vote;
                        if (r_bit == 4'(DATA_BITS - 1)) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_mid) begin
                        r_par_bit  <= w_vote;
                        r_all_zero <= r_all_zero & ~w_vote;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_mid) begin
                        r_stop_err <= w_ferr;
                        r_all_zero <= r_all_zero & ~w_vote;
                        // finishing mid-bit leaves half a bit to catch an immediately following start edge
                        if (w_last) begin
                            r_state <= w_brk ? ST_BREAK : ST_IDLE;
                            r_break <= w_brk;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                ST_BREAK: begin
                    if (w_tick && w_rx) begin
                        r_break <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
            if (w_deliver) begin
                if (!r_valid || IN_RX_READY) begin
                    r_data  <= r_shift;
                    r_perr  <= w_perr;
                    r_ferr  <= w_ferr;
                    r_valid <= 1'b1;
                    r_ovr   <= 1'b0;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && IN_RX_READY) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
            end
        end
    end

    assign OUT_RX_DATA         = r_data;
    assign OUT_RX_VALID        = r_valid;
    assign OUT_RX_PARITY_ERROR = r_perr;
    assign OUT_RX_FRAME_ERROR  = r_ferr;
    assign OUT_RX_OVERRUN      = r_ovr;
    assign OUT_RX_BREAK        = r_break;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: self-checking bench for the oversampling UART receiver
module tb_uart_rx_oversampled;

    localparam int BITC = 432;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1, ready0, ready1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, brk0, brk1;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_hs0 = 0;
    int   n_hs1 = 0;
    int   hs_before;
    bit   hs0_prev = 1'b0;
    bit   hs1_prev = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    vec_t vt[4];

    always #10 clk = ~clk;

    uart_rx_oversampled #(
        .CLOCK_FREQUENCY(50000000), .UART_BAUD_RATE(115200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut0 (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_RX_SERIAL(rx0),
        .OUT_RX_DATA(data0), .OUT_RX_VALID(valid0), .IN_RX_READY(ready0),
        .OUT_RX_PARITY_ERROR(perr0), .OUT_RX_FRAME_ERROR(ferr0),
        .OUT_RX_OVERRUN(ovr0), .OUT_RX_BREAK(brk0)
    );

    uart_rx_oversampled #(
        .CLOCK_FREQUENCY(50000000), .UART_BAUD_RATE(115200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
    ) dut1 (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_RX_SERIAL(rx1),
        .OUT_RX_DATA(data1), .OUT_RX_VALID(valid1), .IN_RX_READY(ready1),
        .OUT_RX_PARITY_ERROR(perr1), .OUT_RX_FRAME_ERROR(ferr1),
        .OUT_RX_OVERRUN(ovr1), .OUT_RX_BREAK(brk1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e = '{d, p, f, o};
        q0.push_back(e);
    endtask

    task automatic push1(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e = '{d, p, f, o};
        q1.push_back(e);
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else rx1 = b;
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    always @(negedge clk) begin
        if (hs0_prev) check("word0_valid_pulse", 32'(valid0), 32'(0));
        hs0_prev = (valid0 === 1'b1) && (ready0 === 1'b1);
        if (hs0_prev) begin
            n_hs0++;
            if (q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL word0_unexpected: got data %0h, expected no word", data0);
            end else begin
                e0 = q0.pop_front();
                check("word0_data", 32'(data0), 32'(e0.data));
                check("word0_perr", 32'(perr0), 32'(e0.perr));
                check("word0_ferr", 32'(ferr0), 32'(e0.ferr));
                check("word0_ovr", 32'(ovr0), 32'(e0.ovr));
            end
        end
    end

    always @(negedge clk) begin
        if (hs1_prev) check("word1_valid_pulse", 32'(valid1), 32'(0));
        hs1_prev = (valid1 === 1'b1) && (ready1 === 1'b1);
        if (hs1_prev) begin
            n_hs1++;
            if (q1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL word1_unexpected: got data %0h, expected no word", data1);
            end else begin
                e1 = q1.pop_front();
                check("word1_data", 32'(data1), 32'(e1.data));
                check("word1_perr", 32'(perr1), 32'(e1.perr));
                check("word1_ferr", 32'(ferr1), 32'(e1.ferr));
                check("word1_ovr", 32'(ovr1), 32'(e1.ovr));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vt[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vt[3] = '{8'h7E, 1'b0, 8'h7E, 1'b1};
        rst_n  = 1'b0;
        rx0    = 1'b1;
        rx1    = 1'b1;
        ready0 = 1'b1;
        ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid0), 32'(0));
        check("rst_data", 32'(data0), 32'(0));
        check("rst_perr", 32'(perr0), 32'(0));
        check("rst_ferr", 32'(ferr0), 32'(0));
        check("rst_ovr", 32'(ovr0), 32'(0));
        check("rst_brk", 32'(brk0), 32'(0));
        check("rst_valid1", 32'(valid1), 32'(0));
        check("rst_brk1", 32'(brk1), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        // back-to-back table frames on the 8N1 receiver alongside 8E1 frames on the parity receiver
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    push0(vt[i].exp_data, 1'b0, vt[i].exp_ferr, 1'b0);
                    send_frame(0, vt[i].data, 1'b0, 1'b0, vt[i].stop);
                end
            end
            begin
                push1(8'h03, 1'b1, 1'b0, 1'b0);
                send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
                push1(8'h03, 1'b0, 1'b0, 1'b0);
                send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
                push1(8'h07, 1'b0, 1'b1, 1'b0);
                send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
            end
        join
        rx0 = 1'b1;
        rx1 = 1'b1;
        repeat (BITC) @(posedge clk);
        #1;
        // line low for 12 bit times: break when enabled, otherwise a zero word with frame error
        hs_before = n_hs0;
        if (!BRK_EN) push0(8'h00, 1'b0, 1'b1, 1'b0);
        rx0 = 1'b0;
        repeat (12 * BITC) @(posedge clk);
        @(negedge clk);
        check("break_active", 32'(brk0), 32'(BRK_EN));
        @(posedge clk);
        #1;
        rx0 = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("break_cleared", 32'(brk0), 32'(0));
        check("break_words", 32'(n_hs0 - hs_before), BRK_EN ? 32'(0) : 32'(1));
        @(posedge clk);
        #1;
        repeat (BITC) @(posedge clk);
        #1;
        // short low glitch rejected by the start vote
        hs_before = n_hs0;
        rx0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx0 = 1'b1;
        repeat (2 * BITC) @(posedge clk);
        @(negedge clk);
        check("glitch_no_word", 32'(n_hs0), 32'(hs_before));
        check("glitch_valid", 32'(valid0), 32'(0));
        @(posedge clk);
        #1;
        push0(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        // overrun: two frames while not ready, held word keeps the first
        ready0 = 1'b0;
        push0(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("ovr_valid", 32'(valid0), 32'(1));
        check("ovr_data", 32'(data0), 32'(8'h11));
        check("ovr_flag", 32'(ovr0), 32'(1));
        @(posedge clk);
        #1;
        ready0 = 1'b1;
        @(posedge clk);
        #1;
        ready0 = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(ovr0), 32'(0));
        check("ovr_valid_cleared", 32'(valid0), 32'(0));
        @(posedge clk);
        #1;
        ready0 = 1'b1;
        drive_bit(0, 1'b1);
        // reset during bit 4 of 0xC3 while the line is low
        hs_before = n_hs0;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        rx0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (BITC - 104) @(posedge clk);
        #1;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        @(negedge clk);
        check("reset_no_word", 32'(n_hs0), 32'(hs_before));
        check("reset_valid", 32'(valid0), 32'(0));
        @(posedge clk);
        #1;
        push0(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        drive_bit(0, 1'b1);
        @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'(0));
        check("q1_drained", 32'(q1.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Parametrised next-generation UART receiver for FPGA designs. It oversamples the RX line, decides each bit by majority vote, and supports 5–9 data bits, optional parity, and 1 or 2 stop bits. Each received word is delivered on a valid/ready handshake together with parity, framing and overrun flags. It sits between the board RX pin and the consuming logic (FIFO, command parser).

## Interface
- CLOCK_FREQUENCY, 50000000: IN_CLOCK frequency, Hz
- UART_BAUD_RATE, 9600: bit rate
- OVERSAMPLE, 16: samples per bit; even, ≥8
- DATA_BITS, 8: data bits per frame, 5..9
- PARITY, 0: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2
- IN_CLOCK  in  1  system clock
- IN_RESET_N  in  1  synchronous, active-low reset
- IN_RX_SERIAL  in  1  asynchronous RX line, idle high
- OUT_RX_DATA  out  DATA_BITS  received word, LSB first on the wire
- OUT_RX_VALID  out  1  word available
- IN_RX_READY  in  1  consumer accepts the word
- OUT_RX_PARITY_ERROR  out  1  parity mismatch for the held word
- OUT_RX_FRAME_ERROR  out  1  a stop bit was sampled 0 for the held word
- OUT_RX_OVERRUN  out  1  one or more frames were lost while the word was held
- OUT_RX_BREAK  out  1  break condition in progress

## Operation
- Reset (IN_RESET_N low at a clock edge) drives all outputs to 0, the state to IDLE, the counters to 0, and both synchronizer flops to 1. The armed flag is cleared. A reset mid-frame aborts the frame and no word is delivered.
- IN_RX_SERIAL passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick generator: DIVISOR = CLOCK_FREQUENCY/(UART_BAUD_RATE*OVERSAMPLE), integer division. DIVISOR < 1 is an elaboration error. It emits a one-cycle tick every DIVISOR clocks and runs freely from reset.
- Sample counter: counts ticks 0..OVERSAMPLE-1 within each bit. With M = OVERSAMPLE/2, the bit value is the majority of the samples taken at ticks M-1, M and M+1.
- States and transitions:
  - IDLE: on a tick with the line high, set armed. When armed and the line is low, clear the sample counter and go to START.
  - START: a voted 1 is a glitch; return to IDLE with no output. A voted 0 goes to DATA.
  - DATA: shift DATA_BITS voted bits, LSB first. Then go to PARITY if PARITY≠0, else to STOP.
  - PARITY: error = XOR(data, parity bit) for even, and its inverse for odd.
  - STOP: vote each of the STOP_BITS bits. If any stop bit votes 0, set the frame error. Complete the frame at tick M+1 of the last stop bit, not at the end of the bit, so the receiver can resync. Then go to IDLE.
- Completion when OUT_RX_VALID=0, or when OUT_RX_VALID=1 and IN_RX_READY=1 in the same cycle: load the data and both error flags, set valid, clear overrun.
- Completion while OUT_RX_VALID=1 and IN_RX_READY=0: discard the new frame and set OUT_RX_OVERRUN. The held word and its flags are unchanged.
- Acceptance without a completion in the same cycle (OUT_RX_VALID=1 and IN_RX_READY=1) clears valid, overrun and both error flags the next cycle.
- Words with errors are still delivered. Error flags qualify OUT_RX_DATA only while valid is high.

## Timing
- Latency from the line falling edge to the first sample: 2 clocks (synchronizer) plus up to 1 tick.
- OUT_RX_VALID rises 1 clock after the tick at M+1 of the last stop bit.
- OUT_RX_DATA and all flags are registered and stay stable while OUT_RX_VALID=1.
- Back-to-back frames with zero idle time are supported. The next start edge is detected from IDLE immediately after completion.
- Worst-case tolerated baud mismatch is about ±(OVERSAMPLE/2-1)/OVERSAMPLE of one bit, accumulated over the frame.

## Configuration
- UART_RX_BREAK_DETECT_EN defined:
  - A frame whose data, parity and stop bits all vote 0 is not delivered.
  - OUT_RX_BREAK goes to 1 and the FSM enters BREAK.
  - BREAK waits for one tick with the line voted high, clears OUT_RX_BREAK, then goes to IDLE.
- UART_RX_BREAK_DETECT_EN undefined:
  - No BREAK state exists, and OUT_RX_BREAK is tied to 0.
  - The same all-zero frame is delivered as data 0 with OUT_RX_FRAME_ERROR=1.

## Structure
- Package uart_pkg holds:
  - parity mode constants (PARITY_NONE/EVEN/ODD)
  - the FSM state typedef (IDLE, START, DATA, PARITY, STOP, BREAK)
  - a majority-of-3 function
  - a parity function
- Sub-module uart_baud_tick, parametrised by DIVISOR, holds the free-running tick counter. It is shared later with the TX successor.

## Test plan
All scenarios run at 50 MHz, 115200 baud, OVERSAMPLE 16, giving DIVISOR 27.
- 8N1, byte 0xA5, IN_RX_READY held 1 -> OUT_RX_VALID pulses for 1 cycle, data 0xA5, all flags 0.
- 8E1 (PARITY=1), byte 0x03 sent with parity bit 1 -> data 0x03, OUT_RX_PARITY_ERROR=1, OUT_RX_FRAME_ERROR=0.
- Line low for 100 clocks, then high -> the start vote is 1, OUT_RX_VALID never rises, and the next frame 0x5A is received correctly.
- Frames 0x11 then 0x22 with IN_RX_READY=0 -> data holds 0x11 and OUT_RX_OVERRUN=1. Then a 1-cycle IN_RX_READY pulse -> valid=0 and overrun=0 the next cycle.
- Byte 0x7E with stop bit forced 0 -> data 0x7E, OUT_RX_FRAME_ERROR=1. With UART_RX_BREAK_DETECT_EN, a line held low for 12 bit times -> OUT_RX_BREAK=1 and no valid; after the line returns high, OUT_RX_BREAK=0 within 1 tick.
- IN_RESET_N pulled low during bit 4 of 0xC3 while the line is still low -> no valid; no frame starts until the line has been seen high, and the next 0x3C is received correctly.
